// File: rtl/avr_serial_tx_pkg.sv
// Shared types and defaults for the FPGA->AVR serial transmitter.
// Holds the FSM encoding and the Mojo clock/baud defaults.
package avr_serial_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    localparam int DEF_CLK_HZ = 50_000_000;
    localparam int DEF_BAUD   = 500_000;

    function automatic int clks_per_bit(
        input int clk_hz,
        input int baud
    );
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/avr_serial_tx_sync_fifo.sv
// Show-ahead synchronous FIFO; rd_data is the head entry when not empty.
// Pointers wrap modulo DEPTH (power of two), count is one bit wider.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/avr_serial_tx.sv
// 8N1 LSB-first transmitter toward the AVR, buffered by a small FIFO.
// New frames start only while the synchronised AVR busy flag is low.
module avr_serial_tx
    import avr_serial_tx_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    input  logic       RX_BUSY,
    output logic       TX,
    output logic       IDLE
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int BW  = $clog2(CPB);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          tx_q;
    logic          ready_q;
    logic          idle_q;
    logic          busy_m;
    logic          busy_s;

    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt_nxt;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          can_start;

    assign READY = ready_q;
    assign TX    = tx_q;
    assign IDLE  = idle_q;

    assign push      = VALID && ready_q && !fifo_full;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign can_start = !fifo_empty && !busy_s;
    assign pop       = can_start &&
                       ((state == S_IDLE) ||
                        ((state == S_STOP) && bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (push),
        .wr_data (DATA),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= RX_BUSY;
            busy_s <= busy_m;
        end
    end

    // READY tracks the post-edge occupancy so it can never admit an overflow.
    always_comb begin
        cnt_nxt = fifo_count;
        unique case (1'b1)
            (push && !pop): cnt_nxt = fifo_count + CW'(1);
            (pop && !push): cnt_nxt = fifo_count - CW'(1);
            default:        cnt_nxt = fifo_count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ready_q <= 1'b1;
            idle_q  <= 1'b1;
        end else begin
            ready_q <= (cnt_nxt != CNT_FULL);
            idle_q  <= (state == S_IDLE) && (fifo_count == '0);
        end
    end

    // TX is driven from the current state, so the line lags the FSM by one edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    tx_q     <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= fifo_head;
                        state <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    tx_q <= shift[0];
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_head;
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avr_serial_tx.sv
// Directed bench for avr_serial_tx with a mid-bit UART decoder.
// Accepted bytes feed a scoreboard checked against decoded frames.
module tb_avr_serial_tx;

    localparam int C = 100;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] DATA = 8'h00;
    logic       VALID = 1'b0;
    logic       RX_BUSY = 1'b0;
    logic       READY;
    logic       TX;
    logic       IDLE;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int frames = 0;
    logic [7:0] exp_q[$];

    avr_serial_tx dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .DATA    (DATA),
        .VALID   (VALID),
        .READY   (READY),
        .RX_BUSY (RX_BUSY),
        .TX      (TX),
        .IDLE    (IDLE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            exp_q.delete();
        end else if (VALID && READY) begin
            exp_q.push_back(DATA);
            acc_cnt++;
        end
    end

    int         d_cnt = 0;
    bit         d_act = 1'b0;
    logic [9:0] d_bits = '0;

    always @(negedge CLK) begin
        if (RESET) begin
            d_act = 1'b0;
        end else begin
            if (!d_act && TX == 1'b0) begin
                d_act = 1'b1;
                d_cnt = 0;
            end
            if (d_act) begin
                if (d_cnt % C == C / 2) begin
                    d_bits[d_cnt / C] = TX;
                end
                if (d_cnt == 9 * C + C / 2) begin
                    d_act = 1'b0;
                    frames++;
                    chk("start_bit", 32'(d_bits[0]), 32'd0);
                    chk("stop_bit", 32'(d_bits[9]), 32'd1);
                    chk("sb_has_byte", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("byte", 32'(d_bits[8:1]),
                            32'(exp_q.pop_front()));
                    end
                end else begin
                    d_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!READY && n < 20000) begin
            tick();
            n++;
        end
        if (!READY) chk("ready_timeout", 32'(READY), 32'd1);
    endtask

    task automatic push(input logic [7:0] b);
        DATA  = b;
        VALID = 1'b1;
        wait_ready();
        tick();
        VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        tick();
        tick();
        while (!IDLE && n < 20000) begin
            tick();
            n++;
        end
        if (!IDLE) chk("idle_timeout", 32'(IDLE), 32'd1);
    endtask

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] v2 [5];
        int p0;
        int f0;
        int a0;
        int x;
        int lows;
        int busy_hi;
        int guard;

        v2[0] = 8'hA5; v2[1] = 8'h3C; v2[2] = 8'hFF;
        v2[3] = 8'h00; v2[4] = 8'h81;

        // 1: reset values, then a single 0x55 frame
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_tx", 32'(TX), 32'd1);
            chk("rst_ready", 32'(READY), 32'd1);
            chk("rst_idle", 32'(IDLE), 32'd1);
        end
        RESET = 1'b0;
        tick();
        f0 = frames;
        push(8'h55);
        p0 = cyc;
        tick();
        chk("t1_tx_n1", 32'(TX), 32'd1);
        tick();
        chk("t1_tx_n2", 32'(TX), 32'd0);
        run_to(p0 + 1000);
        chk("t1_stop", 32'(TX), 32'd1);
        tick();
        chk("t1_idle_lo", 32'(IDLE), 32'd0);
        tick();
        chk("t1_idle_hi", 32'(IDLE), 32'd1);
        chk("t1_frames", 32'(frames - f0), 32'd1);

        // 2: five bytes with VALID held
        tick();
        f0 = frames;
        p0 = 0;
        for (int i = 0; i < 5; i++) begin
            DATA  = v2[i];
            VALID = 1'b1;
            wait_ready();
            tick();
            if (i == 0) p0 = cyc;
        end
        VALID = 1'b0;
        chk("t2_accept_span", 32'(cyc - p0), 32'd4);
        chk("t2_ready_low", 32'(READY), 32'd0);
        run_to(p0 + 1000);
        chk("t2_ready_pre", 32'(READY), 32'd0);
        tick();
        chk("t2_ready_pop", 32'(READY), 32'd1);
        run_to(p0 + 5001);
        chk("t2_idle_lo", 32'(IDLE), 32'd0);
        tick();
        chk("t2_idle_hi", 32'(IDLE), 32'd1);
        chk("t2_frames", 32'(frames - f0), 32'd5);

        // 3: flow control holds the second frame
        f0 = frames;
        push(8'h12);
        p0 = cyc;
        push(8'h34);
        run_to(p0 + 502);
        RX_BUSY = 1'b1;
        run_to(p0 + 1002);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            if (TX == 1'b0) lows++;
            tick();
        end
        chk("t3_held_lows", 32'(lows), 32'd0);
        chk("t3_idle_pend", 32'(IDLE), 32'd0);
        chk("t3_frames1", 32'(frames - f0), 32'd1);
        RX_BUSY = 1'b0;
        x = cyc;
        run_to(x + 3);
        chk("t3_tx_e3", 32'(TX), 32'd1);
        tick();
        chk("t3_tx_e4", 32'(TX), 32'd0);
        wait_idle();
        chk("t3_frames2", 32'(frames - f0), 32'd2);

        // 4: reset during bit 3 of 0xC3 with two bytes queued
        f0 = frames;
        push(8'hC3);
        p0 = cyc;
        push(8'h11);
        push(8'h22);
        run_to(p0 + 2 + 450);
        RESET = 1'b1;
        tick();
        chk("t4_tx", 32'(TX), 32'd1);
        chk("t4_ready", 32'(READY), 32'd1);
        chk("t4_idle", 32'(IDLE), 32'd1);
        tick();
        RESET = 1'b0;
        lows = 0;
        busy_hi = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (TX == 1'b0) lows++;
            if (IDLE == 1'b0) busy_hi++;
        end
        chk("t4_lows", 32'(lows), 32'd0);
        chk("t4_not_idle", 32'(busy_hi), 32'd0);
        chk("t4_frames", 32'(frames - f0), 32'd0);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5a: full FIFO and pop on the same edge
        f0 = frames;
        p0 = 0;
        for (int i = 0; i < 5; i++) begin
            DATA  = 8'(i + 1);
            VALID = 1'b1;
            wait_ready();
            tick();
            if (i == 0) p0 = cyc;
        end
        DATA = 8'h66;
        a0 = acc_cnt;
        run_to(p0 + 1000);
        chk("t5_ready_full", 32'(READY), 32'd0);
        tick();
        chk("t5_no_push_pop", 32'(acc_cnt - a0), 32'd0);
        chk("t5_ready_rise", 32'(READY), 32'd1);
        tick();
        chk("t5_push_after", 32'(acc_cnt - a0), 32'd1);
        VALID = 1'b0;
        chk("t5_ready_refull", 32'(READY), 32'd0);
        wait_idle();
        chk("t5_frames", 32'(frames - f0), 32'd6);

        // 5b: empty FIFO, push while idle
        f0 = frames;
        push(8'h5A);
        chk("t5_tx_n", 32'(TX), 32'd1);
        tick();
        chk("t5_tx_n1", 32'(TX), 32'd1);
        tick();
        chk("t5_tx_n2", 32'(TX), 32'd0);
        wait_idle();
        chk("t5_frames1", 32'(frames - f0), 32'd1);

        // 6: random bytes, VALID and RX_BUSY
        f0 = frames;
        a0 = acc_cnt;
        guard = 0;
        while (acc_cnt - a0 < 30 && guard < 60000) begin
            DATA    = 8'($urandom);
            VALID   = ($urandom_range(0, 3) != 0);
            RX_BUSY = ($urandom_range(0, 9) < 3);
            tick();
            guard++;
        end
        VALID   = 1'b0;
        RX_BUSY = 1'b0;
        chk("t6_accepts", 32'(acc_cnt - a0), 32'd30);
        wait_idle();
        run_to(cyc + 20);
        chk("t6_frames", 32'(frames - f0), 32'(acc_cnt - a0));
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
